midi_transmit: RTL and testbench
================================

# midi_transmit

Serializes MIDI channel-voice messages onto a 31250-baud 8N1 line for the synth's MIDI OUT/THRU port. It is the transmit counterpart of the MIDI input path and takes the same message shape: a 7-bit status with the MSB implied, plus 7-bit data1 and data2. It contains its own baud generator and shift register, and can use running status to omit repeated status bytes. Upstream logic hands it whole messages over a valid/ready handshake.

## Interface
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD_RATE, 31250: line rate. Bit period BIT_CYCLES = CLK_FREQ / BAUD_RATE, using integer floor.
- RUNNING_STATUS, 1: 1 enables omission of a repeated status byte; 0 always sends the status byte.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din_valid  in  1  a message is presented on status/data1/data2.
- din_ready  out  1  the block can accept a message; a transfer occurs on an edge where din_valid && din_ready.
- status  in  7  status byte bits [6:0]; the transmitted byte is {1'b1, status}.
- data1  in  7  first data byte.
- data2  in  7  second data byte; ignored for single-data messages.
- dout  out  1  serial MIDI line; idles high.
- busy  out  1  a message is being shifted out.
- dropped  out  1  one-cycle pulse on the cycle after an unsupported message is accepted.

## Operation
- Reset values: din_ready=1, dout=1, busy=0, dropped=0. Reset also sets state=IDLE, last_status_valid=0, and clears all counters.
- Reset is asynchronous. Asserting it mid-message aborts the message immediately and leaves a truncated byte on the line. No recovery is attempted.
- States: IDLE and SEND.
- IDLE behaviour:
  - din_ready=1.
  - On a transfer, status, data1 and data2 are captured into internal registers. Input changes after capture have no effect.
- Message classification, decided at capture:
  - status[6:4]==3'b111 (system, 0xF0–0xFF) is unsupported. The transfer completes and dropped pulses. Nothing is sent, the state stays IDLE, and last_status is unchanged.
  - status[6:5]==2'b10 (Program Change, Channel Pressure) is a single-data message: 1 data byte.
  - All other statuses carry 2 data bytes.
- Status byte rule:
  - If RUNNING_STATUS==1, last_status_valid==1 and status==last_status, the status byte is skipped.
  - Otherwise the status byte is sent first.
  - In both cases last_status<=status and last_status_valid<=1 at capture.
- Byte count N is one of: 1 (single-data with running status), 2, or 3.
- SEND behaviour:
  - Bytes go out in the order status (if sent), data1, then data2 (if present).
  - Each frame is a start bit (0), 8 data bits LSB first (bit 7 of every data byte is 0), and one stop bit (1).
  - A baud counter runs 0..BIT_CYCLES-1 for each bit. A bit counter runs 0..9 for each frame. A byte counter runs 0..N-1.
  - Frames within a message are contiguous, with no idle gap between stop and the next start.
  - After the last stop bit completes, the state returns to IDLE.
- busy=1 exactly while in SEND. din_ready = !busy.

## Timing
- Transfer at edge T:
  - din_ready=0 from edge T.
  - dout=0 (start bit) from edge T, and each bit is held BIT_CYCLES cycles.
  - The final stop bit ends at edge T + N*10*BIT_CYCLES. din_ready=1 and busy=0 from that edge, so a new transfer can occur on that same edge.
- Back-to-back messages: the next start bit immediately follows the previous stop bit; the minimum gap is 0 bit-times.
- Unsupported message: dropped=1 for the single cycle after edge T, din_ready stays 1, and dout stays 1.
- din_valid while din_ready=0 is ignored. Upstream must hold it; nothing is queued.
- dout is driven directly from a register, with no combinational path from the inputs.

## Test plan
Use CLK_FREQ=312500 so BIT_CYCLES=10.
- Note-on after reset: status=7'h10, data1=7'h3C, data2=7'h64 -> frames 0x90, 0x3C, 0x64, each start/LSB-first/stop at 10 cycles per bit. din_ready returns 300 cycles after the transfer.
- Running status: the same Note-on again with data1=7'h3E, data2=7'h00 -> only 0x3E and 0x00 are sent, in 200 cycles. Repeat with RUNNING_STATUS=0 -> 3 frames.
- Program change: status=7'h45, data1=7'h07, data2=7'h7F -> frames 0xC5, 0x07 only, in 200 cycles. Then Note-on status=7'h10 -> status byte 0x90 is re-sent.
- Unsupported: status=7'h78 -> dropped is high for 1 cycle, dout stays 1, and din_ready stays 1. A following status=7'h45 message still omits its status byte.
- Busy hold-off: change din_valid and the data inputs while busy=1 -> the transmitted bytes equal the captured values, and only one message is sent per transfer.
- Reset mid-frame: pull rst_n low during bit 4 of data1 -> dout=1, din_ready=1, busy=0 immediately. The next Note-on 7'h10 sends its status byte, because last_status was cleared.

Source files
------------

// File: rtl/midi_transmit.sv
// midi_transmit: serialises MIDI channel-voice messages onto an 8N1 line.
// Each message is a status byte (MSB implied), data1 and an optional data2.
// Running status can drop a repeated status byte. The line idles high.
//
// Handshake: a message transfers on a rising edge where din_valid && din_ready.
// din_ready is high only in IDLE. When din_ready is low, din_valid is ignored
// and nothing is queued, so upstream must hold the message until it is accepted.
module midi_transmit #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD_RATE      = 31250,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [6:0] status,
    input  logic [6:0] data1,
    input  logic [6:0] data2,
    output logic       dout,
    output logic       busy,
    output logic       dropped
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;        // 0 = start, 1..8 = data, 9 = stop
    logic [1:0]        byte_q, byte_d;
    logic [1:0]        last_byte_q, last_byte_d;  // N-1 for this message
    logic [7:0]        byte0_q, byte0_d;    // bytes stored in send order
    logic [7:0]        byte1_q, byte1_d;
    logic [7:0]        byte2_q, byte2_d;
    logic [6:0]        last_status_q, last_status_d;
    logic              last_valid_q, last_valid_d;
    logic              dout_q, dout_d;
    logic              dropped_q, dropped_d;

    logic       accept;
    logic       unsupported;
    logic       single_data;
    logic       skip_status;
    logic [7:0] cur_byte;

    assign busy      = (state_q == SEND);
    assign din_ready = !busy;
    assign dout      = dout_q;
    assign dropped   = dropped_q;

    assign accept      = (state_q == IDLE) && din_valid;
    assign unsupported = (status[6:4] == 3'b111);
    assign single_data = (status[6:5] == 2'b10);
    assign skip_status = (RUNNING_STATUS != 0) && last_valid_q && (status == last_status_q);

    // Select the byte currently being framed.
    always_comb begin
        cur_byte = byte0_q;
        case (byte_q)
            2'd1:    cur_byte = byte1_q;
            2'd2:    cur_byte = byte2_q;
            default: cur_byte = byte0_q;
        endcase
    end

    // Next-state logic: capture/classify in IDLE, bit and byte sequencing in SEND.
    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        byte_d        = byte_q;
        last_byte_d   = last_byte_q;
        byte0_d       = byte0_q;
        byte1_d       = byte1_q;
        byte2_d       = byte2_q;
        last_status_d = last_status_q;
        last_valid_d  = last_valid_q;
        dout_d        = dout_q;
        dropped_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (unsupported) begin
                        dropped_d = 1'b1;
                    end else begin
                        state_d       = SEND;
                        dout_d        = 1'b0;  // start bit of the first frame
                        baud_d        = '0;
                        bit_d         = 4'd0;
                        byte_d        = 2'd0;
                        last_byte_d   = {1'b0, ~skip_status} + {1'b0, ~single_data};
                        last_status_d = status;
                        last_valid_d  = 1'b1;
                        if (skip_status) begin
                            byte0_d = {1'b0, data1};
                            byte1_d = {1'b0, data2};
                            byte2_d = 8'h00;
                        end else begin
                            byte0_d = {1'b1, status};
                            byte1_d = {1'b0, data1};
                            byte2_d = {1'b0, data2};
                        end
                    end
                end
            end
            SEND: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        if (byte_q == last_byte_q) begin
                            state_d = IDLE;
                            dout_d  = 1'b1;
                        end else begin
                            byte_d = byte_q + 2'd1;
                            bit_d  = 4'd0;
                            dout_d = 1'b0;  // next frame starts with no gap
                        end
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        dout_d = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any frame in flight and forgets running status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            baud_q        <= '0;
            bit_q         <= 4'd0;
            byte_q        <= 2'd0;
            last_byte_q   <= 2'd0;
            byte0_q       <= 8'h00;
            byte1_q       <= 8'h00;
            byte2_q       <= 8'h00;
            last_status_q <= 7'h00;
            last_valid_q  <= 1'b0;
            dout_q        <= 1'b1;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            byte_q        <= byte_d;
            last_byte_q   <= last_byte_d;
            byte0_q       <= byte0_d;
            byte1_q       <= byte1_d;
            byte2_q       <= byte2_d;
            last_status_q <= last_status_d;
            last_valid_q  <= last_valid_d;
            dout_q        <= dout_d;
            dropped_q     <= dropped_d;
        end
    end

endmodule

// File: tb/tb_midi_transmit.sv
// Bench for midi_transmit: two instances (running status on / off) at
// 10 clocks per bit. A reference model lists the bytes each message should
// produce; per-instance line monitors decode frames and compare in order.
module tb_midi_transmit;

    localparam int BC = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       din_valid_r [2];
    logic [6:0] status_r    [2];
    logic [6:0] data1_r     [2];
    logic [6:0] data2_r     [2];
    logic       din_ready_w [2];
    logic       dout_w      [2];
    logic       busy_w      [2];
    logic       dropped_w   [2];

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    int checks = 0;
    int errors = 0;

    bit         m_lsv [2];
    logic [6:0] m_ls  [2];
    int         m_rs  [2] = '{1, 0};

    midi_transmit #(.CLK_FREQ(312500), .BAUD_RATE(31250), .RUNNING_STATUS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .din_valid(din_valid_r[0]), .din_ready(din_ready_w[0]),
        .status(status_r[0]), .data1(data1_r[0]), .data2(data2_r[0]),
        .dout(dout_w[0]), .busy(busy_w[0]), .dropped(dropped_w[0])
    );

    midi_transmit #(.CLK_FREQ(312500), .BAUD_RATE(31250), .RUNNING_STATUS(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .din_valid(din_valid_r[1]), .din_ready(din_ready_w[1]),
        .status(status_r[1]), .data1(data1_r[1]), .data2(data2_r[1]),
        .dout(dout_w[1]), .busy(busy_w[1]), .dropped(dropped_w[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: which bytes a message produces, in order.
    task automatic model(input int idx, input logic [6:0] st, input logic [6:0] d1,
                         input logic [6:0] d2, output int n, output bit drop);
        logic [7:0] bytes[$];
        drop = (st >= 7'h70);                 // 0xF0..0xFF system messages
        n = 0;
        if (!drop) begin
            if (!(m_rs[idx] != 0 && m_lsv[idx] && m_ls[idx] == st))
                bytes.push_back({1'b1, st});
            bytes.push_back({1'b0, d1});
            if (!(st >= 7'h40 && st < 7'h60)) // 0xC0..0xDF carry one data byte
                bytes.push_back({1'b0, d2});
            m_ls[idx]  = st;
            m_lsv[idx] = 1'b1;
            n = bytes.size();
            foreach (bytes[i]) begin
                if (idx == 0) exp_q0.push_back(bytes[i]);
                else          exp_q1.push_back(bytes[i]);
            end
        end
    endtask

    // Line monitor: find a start bit, sample mid-bit, compare against the queue.
    task automatic mon(input int idx);
        logic [7:0] b;
        logic [7:0] e;
        logic       stop_bit;
        logic       ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && dout_w[idx] === 1'b0) begin
                ok = 1'b1;
                repeat (4) begin @(negedge clk); if (!rst_n) ok = 1'b0; end
                for (int i = 0; i < 8; i++) begin
                    repeat (BC) begin @(negedge clk); if (!rst_n) ok = 1'b0; end
                    b[i] = dout_w[idx];
                end
                repeat (BC) begin @(negedge clk); if (!rst_n) ok = 1'b0; end
                stop_bit = dout_w[idx];
                if (ok) begin
                    e = 8'hxx;
                    if (idx == 0) begin
                        if (exp_q0.size() != 0) e = exp_q0.pop_front();
                    end else begin
                        if (exp_q1.size() != 0) e = exp_q1.pop_front();
                    end
                    chk($sformatf("frame_dut%0d", idx), {23'd0, stop_bit, b}, {23'd0, 1'b1, e});
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    task automatic wiggle_inputs(input int idx);
        din_valid_r[idx] = 1'($urandom_range(0, 1));
        status_r[idx]    = 7'($urandom_range(0, 127));
        data1_r[idx]     = 7'($urandom_range(0, 127));
        data2_r[idx]     = 7'($urandom_range(0, 127));
    endtask

    // Driver: present one message, then check handshake timing until ready returns.
    // abort_at > 0 pulls reset that many cycles after the transfer.
    task automatic send(input int idx, input logic [6:0] st, input logic [6:0] d1,
                        input logic [6:0] d2, input bit wiggle, input int abort_at);
        int  n;
        bit  drop;
        int  k;
        k = 0;
        @(negedge clk);
        while (!din_ready_w[idx] && k < 2000) begin @(negedge clk); k++; end
        chk($sformatf("ready_before_dut%0d", idx), {31'd0, din_ready_w[idx]}, 32'd1);
        status_r[idx]    = st;
        data1_r[idx]     = d1;
        data2_r[idx]     = d2;
        din_valid_r[idx] = 1'b1;
        @(posedge clk);
        model(idx, st, d1, d2, n, drop);
        @(negedge clk);
        if (drop) begin
            din_valid_r[idx] = 1'b0;
            chk("drop_pulse", {31'd0, dropped_w[idx]}, 32'd1);
            chk("drop_ready", {31'd0, din_ready_w[idx]}, 32'd1);
            chk("drop_dout", {31'd0, dout_w[idx]}, 32'd1);
            @(negedge clk);
            chk("drop_pulse_end", {31'd0, dropped_w[idx]}, 32'd0);
            chk("drop_dout_after", {31'd0, dout_w[idx]}, 32'd1);
        end else begin
            if (wiggle) wiggle_inputs(idx);
            else        din_valid_r[idx] = 1'b0;
            chk("start_ready_low", {31'd0, din_ready_w[idx]}, 32'd0);
            chk("start_busy", {31'd0, busy_w[idx]}, 32'd1);
            chk("start_bit", {31'd0, dout_w[idx]}, 32'd0);
            k = 0;
            while (!din_ready_w[idx] && k < 400) begin
                @(negedge clk);
                k++;
                if (wiggle) begin
                    if (k < 100) wiggle_inputs(idx);
                    else         din_valid_r[idx] = 1'b0;
                end
                if (abort_at != 0 && k == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_dout", {31'd0, dout_w[idx]}, 32'd1);
                    chk("rst_ready", {31'd0, din_ready_w[idx]}, 32'd1);
                    chk("rst_busy", {31'd0, busy_w[idx]}, 32'd0);
                    exp_q0.delete();
                    exp_q1.delete();
                    m_lsv[0] = 1'b0;
                    m_lsv[1] = 1'b0;
                    return;
                end
            end
            chk($sformatf("ready_return_dut%0d", idx), k, n * 10 * BC);
            chk("busy_end", {31'd0, busy_w[idx]}, 32'd0);
        end
    endtask

    initial begin
        logic [6:0] st;
        logic [6:0] prev;
        for (int i = 0; i < 2; i++) begin
            din_valid_r[i] = 1'b0;
            status_r[i]    = 7'h00;
            data1_r[i]     = 7'h00;
            data2_r[i]     = 7'h00;
            m_lsv[i]       = 1'b0;
            m_ls[i]        = 7'h00;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", {31'd0, din_ready_w[i]}, 32'd1);
            chk("reset_dout", {31'd0, dout_w[i]}, 32'd1);
            chk("reset_busy", {31'd0, busy_w[i]}, 32'd0);
            chk("reset_dropped", {31'd0, dropped_w[i]}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: running status enabled
        send(0, 7'h10, 7'h3C, 7'h64, 1'b0, 0);  // 90 3C 64
        send(0, 7'h10, 7'h3E, 7'h00, 1'b0, 0);  // 3E 00
        send(0, 7'h45, 7'h07, 7'h7F, 1'b0, 0);  // C5 07
        send(0, 7'h10, 7'h40, 7'h20, 1'b0, 0);  // 90 re-sent
        send(0, 7'h45, 7'h01, 7'h02, 1'b0, 0);  // C5 01
        send(0, 7'h78, 7'h11, 7'h22, 1'b0, 0);  // dropped
        send(0, 7'h45, 7'h03, 7'h04, 1'b0, 0);  // 03 only
        send(0, 7'h20, 7'h55, 7'h2A, 1'b1, 0);  // inputs disturbed while busy
        send(0, 7'h30, 7'h5A, 7'h33, 1'b0, 155); // reset during data1 bit 4
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        send(0, 7'h10, 7'h3C, 7'h64, 1'b0, 0);  // status byte sent again

        // Directed: running status disabled
        send(1, 7'h10, 7'h3C, 7'h64, 1'b0, 0);
        send(1, 7'h10, 7'h3E, 7'h00, 1'b0, 0);
        send(1, 7'h45, 7'h07, 7'h7F, 1'b0, 0);

        // Random messages, biased toward repeating the previous status
        prev = 7'h10;
        for (int i = 0; i < 35; i++) begin
            st = ($urandom_range(0, 2) == 0) ? prev : 7'($urandom_range(0, 127));
            send((i < 25) ? 0 : 1, st, 7'($urandom_range(0, 127)),
                 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 0);
            prev = st;
        end

        for (int k = 0; k < 1000 && (exp_q0.size() != 0 || exp_q1.size() != 0); k++)
            @(negedge clk);
        chk("queue0_empty", exp_q0.size(), 32'd0);
        chk("queue1_empty", exp_q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
